// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit_pkg
//  Purpose  : RV32I memory funct3 codes, LSU error codes, FSM state type and
//             the illegal-funct3 decode shared by the load/store unit.
//  Revision : 1.0  initial release
// ============================================================================
package load_store_unit_pkg;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  localparam logic [1:0] LSU_ERR_OK         = 2'b00;
  localparam logic [1:0] LSU_ERR_MISALIGNED = 2'b01;
  localparam logic [1:0] LSU_ERR_TIMEOUT    = 2'b10;
  localparam logic [1:0] LSU_ERR_ILLEGAL    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10,
    ST_ERR  = 2'b11
  } lsu_state_e;

  // Stores only know SB/SH/SW; loads reject the three unused encodings.
  function automatic logic funct3_illegal(input logic is_store, input logic [2:0] f3);
    if (is_store) begin
      return !((f3 == FUNCT3_SB) || (f3 == FUNCT3_SH) || (f3 == FUNCT3_SW));
    end
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_align
//  Purpose  : Combinational byte-lane steering: byte enables, replicated
//             store data, extended load data and misalignment detection.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_align (
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_ext,
  output logic        misaligned
);

  logic [31:0] w_shifted;

  // Decode access size from funct3[1:0]; funct3[2] selects zero extension.
  always_comb begin
    be         = '0;
    wdata      = '0;
    load_ext   = '0;
    misaligned = 1'b0;
    w_shifted  = rdata >> {addr_lo, 3'b000};
    case (funct3[1:0])
      2'b00: begin
        be       = 4'b0001 << addr_lo;
        wdata    = {4{store_data[7:0]}};
        load_ext = funct3[2] ? {24'b0, w_shifted[7:0]}
                             : {{24{w_shifted[7]}}, w_shifted[7:0]};
      end
      2'b01: begin
        be         = 4'b0011 << addr_lo;
        wdata      = {2{store_data[15:0]}};
        misaligned = addr_lo[0];
        load_ext   = funct3[2] ? {16'b0, w_shifted[15:0]}
                               : {{16{w_shifted[15]}}, w_shifted[15:0]};
      end
      2'b10: begin
        be         = 4'b1111;
        wdata      = store_data;
        misaligned = (addr_lo != 2'b00);
        load_ext   = w_shifted;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : Execute-to-memory stage: one data-bus transaction per request,
//             with misalignment, illegal funct3 and bus-timeout reporting.
//  Revision : 1.0  initial release
// ============================================================================
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_res,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err_code,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  // Last counter value still inside the wait window; the next miss times out.
  localparam logic [7:0] C_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_e  state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_data_q, store_data_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] load_data_q, load_data_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [1:0]  w_sel_addr_lo;
  logic [2:0]  w_sel_funct3;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_ext;
  logic        w_misaligned;
  logic        w_in_req;

  // In IDLE the aligner decodes the live request; afterwards the latched one.
  assign w_sel_addr_lo = (state_q == ST_IDLE) ? alu_res[1:0] : addr_q[1:0];
  assign w_sel_funct3  = (state_q == ST_IDLE) ? funct3 : funct3_q;

  lsu_align u_align (
    .addr_lo    (w_sel_addr_lo),
    .funct3     (w_sel_funct3),
    .store_data (store_data_q),
    .rdata      (mem_rdata),
    .be         (w_be),
    .wdata      (w_wdata),
    .load_ext   (w_load_ext),
    .misaligned (w_misaligned)
  );

  // State register and request/result holding registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      is_store_q   <= 1'b0;
      funct3_q     <= '0;
      addr_q       <= '0;
      store_data_q <= '0;
      err_q        <= LSU_ERR_OK;
      load_data_q  <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      store_data_q <= store_data_d;
      err_q        <= err_d;
      load_data_q  <= load_data_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state logic: accept in IDLE, wait for ack or timeout in REQ.
  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    store_data_d = store_data_q;
    err_d        = err_q;
    load_data_d  = load_data_q;
    cnt_d        = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          is_store_d   = is_store;
          funct3_d     = funct3;
          addr_d       = alu_res;
          store_data_d = store_data;
          if (funct3_illegal(is_store, funct3)) begin
            err_d   = LSU_ERR_ILLEGAL;
            state_d = ST_ERR;
          end else if (w_misaligned) begin
            err_d   = LSU_ERR_MISALIGNED;
            state_d = ST_ERR;
          end else begin
            err_d   = LSU_ERR_OK;
            cnt_d   = '0;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          if (!is_store_q) begin
            load_data_d = w_load_ext;
          end
          state_d = ST_RESP;
        end else begin
          if (cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
          end
          if (cnt_q >= C_TIMEOUT_LAST) begin
            err_d   = LSU_ERR_TIMEOUT;
            state_d = ST_ERR;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign w_in_req  = (state_q == ST_REQ);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_RESP) || (state_q == ST_ERR);
  assign err_code  = done ? err_q : LSU_ERR_OK;
  assign load_data = load_data_q;
  assign mem_req   = w_in_req;
  assign mem_we    = w_in_req & is_store_q;
  assign mem_addr  = w_in_req ? {addr_q[31:2], 2'b00} : '0;
  assign mem_be    = w_in_req ? w_be : '0;
  assign mem_wdata = w_in_req ? w_wdata : '0;

endmodule
`default_nettype wire
